mem_arbiter: RTL and testbench

Two-master arbiter that shares the SoC's single memory/peripheral bus port between the core's instruction-fetch unit (m0, read-only) and its load/store unit (m1, read/write). It sits between the rv32 core and the BRAM, LED and UART decode inside `soc`. It serialises accesses with round-robin priority, one outstanding transaction at a time. A watchdog aborts any access the slave never acknowledges.

---
 rtl/soc_pkg.sv | 16 +
 rtl/arb_watchdog.sv | 38 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared bus-fabric types and default widths for the soc
package soc_pkg;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      M_FETCH = 1'b0,
      M_DATA  = 1'b1
   } master_t;
endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - saturating busy-cycle counter with a registered expiry pulse
module arb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          expired_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Expiry is flagged only on the edge the count first lands on LIMIT.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= (cnt_d == LIMIT) && (cnt_q != LIMIT);
      end
   end

   assign expired = expired_q;
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
module mem_arbiter
   import soc_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                m0_req,
   input  logic [ADDR_W-1:0]   m0_addr,
   output logic                m0_done,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic                m0_err,
   input  logic                m1_req,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic                m1_we,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic                m1_done,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                m1_err,
   output logic                mem_req,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata
);
   arb_state_t state_q;
   master_t    last_grant_q, owner_q, pick;
   logic       pick_valid;
   logic       wd_expired;

   logic                mem_req_q, mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [DATA_W/8-1:0] mem_wstrb_q;
   logic                m0_done_q, m0_err_q, m1_done_q, m1_err_q;
   logic [DATA_W-1:0]   m0_rdata_q, m1_rdata_q;

   always_comb begin
      pick_valid = m0_req | m1_req;
      pick       = M_FETCH;
      if (m0_req && m1_req) begin
         pick = (last_grant_q == M_FETCH) ? M_DATA : M_FETCH;
      end else if (m1_req) begin
         pick = M_DATA;
      end
   end

   // Held in clear for all of IDLE so every grant starts BUSY from zero.
   arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_q == ARB_IDLE),
      .enable  (state_q == ARB_BUSY),
      .expired (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ARB_IDLE;
         last_grant_q <= M_DATA;
         owner_q      <= M_FETCH;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= '0;
         m0_done_q    <= 1'b0;
         m0_rdata_q   <= '0;
         m0_err_q     <= 1'b0;
         m1_done_q    <= 1'b0;
         m1_rdata_q   <= '0;
         m1_err_q     <= 1'b0;
      end else begin
         m0_done_q <= 1'b0;
         m1_done_q <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (pick_valid) begin
                  owner_q      <= pick;
                  last_grant_q <= pick;
                  mem_req_q    <= 1'b1;
                  state_q      <= ARB_BUSY;
                  if (pick == M_FETCH) begin
                     mem_addr_q  <= m0_addr;
                     mem_we_q    <= 1'b0;
                     mem_wdata_q <= '0;
                     mem_wstrb_q <= '0;
                  end else begin
                     mem_addr_q  <= m1_addr;
                     mem_we_q    <= m1_we;
                     mem_wdata_q <= m1_wdata;
                     mem_wstrb_q <= m1_wstrb;
                  end
               end
            end
            ARB_BUSY: begin
               // An ack coinciding with expiry still completes the access cleanly.
               if (mem_ack || wd_expired) begin
                  mem_req_q <= 1'b0;
                  state_q   <= ARB_RESP;
                  if (owner_q == M_FETCH) begin
                     m0_done_q  <= 1'b1;
                     m0_rdata_q <= mem_ack ? mem_rdata : '0;
                     m0_err_q   <= !mem_ack;
                  end else begin
                     m1_done_q  <= 1'b1;
                     m1_rdata_q <= mem_ack ? mem_rdata : '0;
                     m1_err_q   <= !mem_ack;
                  end
               end
            end
            ARB_RESP: state_q <= ARB_IDLE;
            default:  state_q <= ARB_IDLE;
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign m0_done   = m0_done_q;
   assign m0_rdata  = m0_rdata_q;
   assign m0_err    = m0_err_q;
   assign m1_done   = m1_done_q;
   assign m1_rdata  = m1_rdata_q;
   assign m1_err    = m1_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter with TIMEOUT=4
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m1_req, m1_we, mem_ack;
   logic [31:0] m0_addr, m1_addr, m1_wdata, mem_rdata;
   logic [3:0]  m1_wstrb;
   logic        m0_done, m0_err, m1_done, m1_err, mem_req, mem_we;
   logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;

   typedef struct {
      bit          m;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e;
   logic [31:0] mdl_rdata [2];
   logic        mdl_err [2];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          prev, n_req, t0;
   bit          got, mm;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input bit m, input logic [31:0] d, input logic err);
      exp_t x;
      x.m = m;
      x.rdata = d;
      x.err = err;
      sb_q.push_back(x);
   endtask

   // Scoreboard: every done pulse must match the oldest expectation; the idle master must hold.
   always @(negedge clk) begin
      if (m0_done || m1_done) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_done", 32'({m1_done, m0_done}), 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_done_owner", 32'({m1_done, m0_done}), e.m ? 32'd2 : 32'd1);
            if (e.m) begin
               chk("sb_m1_rdata", m1_rdata, e.rdata);
               chk("sb_m1_err", 32'(m1_err), 32'(e.err));
               chk("sb_m0_hold_rdata", m0_rdata, mdl_rdata[0]);
               chk("sb_m0_hold_err", 32'(m0_err), 32'(mdl_err[0]));
            end else begin
               chk("sb_m0_rdata", m0_rdata, e.rdata);
               chk("sb_m0_err", 32'(m0_err), 32'(e.err));
               chk("sb_m1_hold_rdata", m1_rdata, mdl_rdata[1]);
               chk("sb_m1_hold_err", 32'(m1_err), 32'(mdl_err[1]));
            end
            mdl_rdata[e.m] = e.rdata;
            mdl_err[e.m]   = e.err;
         end
      end
   end

   task automatic run_xact(input bit m, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [31:0] rdata, input int waits, input string tag);
      if (m) begin
         m1_req = 1'b1; m1_addr = addr; m1_we = we; m1_wdata = wdata; m1_wstrb = wstrb;
      end else begin
         m0_req = 1'b1; m0_addr = addr;
      end
      push_exp(m, rdata, 1'b0);
      @(negedge clk);
      chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
      chk({tag, "_mem_addr"}, mem_addr, addr);
      chk({tag, "_mem_we"}, 32'(mem_we), m ? 32'(we) : 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, m ? wdata : 32'd0);
      chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), m ? 32'(wstrb) : 32'd0);
      repeat (waits) @(negedge clk);
      mem_ack = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      mem_ack = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
      chk({tag, "_done"}, 32'({m1_done, m0_done}), m ? 32'd2 : 32'd1);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=hang expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0; mem_ack = 1'b0;
      m0_addr = '0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0; mem_rdata = '0;
      mdl_rdata[0] = '0; mdl_rdata[1] = '0; mdl_err[0] = 1'b0; mdl_err[1] = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ctrl", 32'({mem_req, mem_we, m0_done, m1_done, m0_err, m1_err}), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_rdata", m0_rdata | m1_rdata | mem_wdata, 32'd0);

      // m0 alone, zero-wait, followed by spurious acks in RESP and IDLE
      reset = 1'b1; m0_req = 1'b1; m0_addr = 32'h0000_0010;
      push_exp(1'b0, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      chk("t1_mem_req", 32'(mem_req), 32'd1);
      chk("t1_mem_addr", mem_addr, 32'h10);
      chk("t1_mem_we", 32'(mem_we), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("t1_mem_req_drop", 32'(mem_req), 32'd0);
      chk("t1_done", 32'({m1_done, m0_done}), 32'd1);
      m0_req = 1'b0; mem_rdata = 32'h1111_1111;
      @(negedge clk);
      chk("sp_resp_done", 32'({m1_done, m0_done}), 32'd0);
      chk("sp_resp_rdata", m0_rdata, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("sp_idle_mem_req", 32'(mem_req), 32'd0);
      chk("sp_idle_rdata", m0_rdata, 32'hDEAD_BEEF);
      mem_ack = 1'b0;
      @(negedge clk);
      chk("sp_idle_done", 32'({m1_done, m0_done, mem_req}), 32'd0);

      // m1 write never acked: watchdog abort, then m0 served normally
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h2000; m1_wdata = 32'h55; m1_wstrb = 4'hF;
      push_exp(1'b1, 32'h0, 1'b1);
      n_req = 0; got = 1'b0; t0 = cyc;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (m1_done) got = 1'b1;
         else if (mem_req) begin
            if (n_req == 0) chk("to_mem_wdata", mem_wdata, 32'h55);
            n_req++;
         end
      end
      chk("to_done_seen", 32'(got), 32'd1);
      chk("to_req_cycles", 32'(n_req), 32'd5);
      chk("to_latency", 32'(cyc - t0), 32'd6);
      m1_req = 1'b0;
      @(negedge clk);
      run_xact(1'b0, 32'h0000_0024, 1'b0, 32'h0, 4'h0, 32'h0BAD_F00D, 0, "post_to");

      // ack in the same cycle the watchdog expires
      run_xact(1'b0, 32'h0000_0030, 1'b0, 32'h0, 4'h0, 32'hCAFE_0004, 4, "ack_exp");
      run_xact(1'b1, 32'h0000_0034, 1'b0, 32'h0, 4'h0, 32'h7777_0003, 3, "m1_wait3");

      // reset mid-BUSY on an m1 read
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
      @(negedge clk);
      chk("rb_mem_req", 32'(mem_req), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("rb_ctrl", 32'({mem_req, mem_we, m0_done, m1_done, m0_err, m1_err}), 32'd0);
      chk("rb_mem_addr", mem_addr, 32'd0);
      chk("rb_m0_rdata", m0_rdata, 32'd0);
      chk("rb_m1_rdata", m1_rdata, 32'd0);
      chk("rb_wdata_wstrb", mem_wdata | 32'(mem_wstrb), 32'd0);
      mdl_rdata[0] = '0; mdl_rdata[1] = '0; mdl_err[0] = 1'b0; mdl_err[1] = 1'b0;

      // both masters continuously requesting after release, zero-wait slave
      reset = 1'b1;
      m0_req = 1'b1; m0_addr = 32'h20;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h1000; m1_wdata = 32'hF; m1_wstrb = 4'b0001;
      prev = 0;
      for (int t = 0; t < 4; t++) begin
         mm = (t % 2) == 1;
         @(negedge clk);
         chk("rr_mem_req", 32'(mem_req), 32'd1);
         chk("rr_mem_we", 32'(mem_we), 32'(mm));
         chk("rr_mem_addr", mem_addr, mm ? 32'h1000 : 32'h20);
         chk("rr_mem_wdata", mem_wdata, mm ? 32'hF : 32'h0);
         chk("rr_mem_wstrb", 32'(mem_wstrb), mm ? 32'd1 : 32'd0);
         push_exp(mm, 32'hA000_0000 + 32'(t), 1'b0);
         mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + 32'(t);
         @(negedge clk);
         mem_ack = 1'b0;
         chk("rr_done", 32'({m1_done, m0_done}), mm ? 32'd2 : 32'd1);
         if (t > 0) chk("rr_spacing", 32'(cyc - prev), 32'd3);
         prev = cyc;
         if (t == 3) begin
            m0_req = 1'b0; m1_req = 1'b0;
         end
         @(negedge clk);
         chk("rr_idle_mem_req", 32'(mem_req), 32'd0);
      end

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
